// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
// Define MULDIV_DIV_EN to build the DIV/DIVU datapath; otherwise only MULT/MULTU/MTHI/MTLO exist.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_neg_res;
    logic        r_done;

    logic        w_idle;
    logic        w_op_signed;
    logic        w_op_mul;
    logic        w_op_div;
    logic        w_go;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_prod_signed;
    logic [63:0] w_step;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_idle      = (r_state == S_IDLE);
    assign w_op_signed = ~op[0];
    assign w_op_mul    = (op[2:1] == 2'b00);
    assign w_go        = start & w_idle & (w_op_mul | w_op_div);
    assign w_mag_a     = (w_op_signed && busA[31]) ? -busA : busA;
    assign w_mag_b     = (w_op_signed && busB[31]) ? -busB : busB;

    // Shift-add: r_prod holds {partial product, remaining multiplier bits}
    assign w_mul_sum     = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opa} : 33'd0);
    assign w_mul_next    = {w_mul_sum, r_prod[31:1]};
    assign w_prod_signed = r_neg_res ? -r_prod : r_prod;

`ifdef MULDIV_DIV_EN
    logic        r_is_div;
    logic        r_neg_rem;
    logic        r_dz;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [63:0] w_div_next;
    logic        w_fix_dz;

    assign w_op_div = (op[2:1] == 2'b01);

    // Restoring division: r_prod holds {remainder, dividend bits shifting into quotient}
    assign w_div_shift = {r_prod[63:32], r_prod[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_next  = w_div_ge ? {w_div_diff[31:0], r_prod[30:0], 1'b1}
                                  : {w_div_shift[31:0], r_prod[30:0], 1'b0};
    assign w_step      = r_is_div ? w_div_next : w_mul_next;

    always_comb begin
        w_fix_hi = w_prod_signed[63:32];
        w_fix_lo = w_prod_signed[31:0];
        w_fix_dz = 1'b0;
        if (r_is_div) begin
            if (r_opb == 32'd0) begin
                // Reconstruct the original dividend from magnitude and sign
                w_fix_hi = r_neg_rem ? -r_opa : r_opa;
                w_fix_lo = 32'hFFFF_FFFF;
                w_fix_dz = 1'b1;
            end else begin
                w_fix_hi = r_neg_rem ? -r_prod[63:32] : r_prod[63:32];
                w_fix_lo = r_neg_res ? -r_prod[31:0] : r_prod[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_dz <= 1'b0;
            if (w_go) begin
                r_is_div  <= w_op_div;
                r_neg_rem <= w_op_signed & busA[31];
            end
            if (r_state == S_FIX) begin
                r_dz <= w_fix_dz;
            end
        end
    end

    assign div_zero = r_dz;
`else
    assign w_op_div = 1'b0;
    assign w_step   = w_mul_next;
    assign w_fix_hi = w_prod_signed[63:32];
    assign w_fix_lo = w_prod_signed[31:0];
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_RUN;
            S_RUN:   if (r_cnt == 6'd31) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 6'd0;
            r_prod    <= 64'd0;
            r_opa     <= 32'd0;
            r_opb     <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_neg_res <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_cnt     <= 6'd0;
                        r_opa     <= w_mag_a;
                        r_opb     <= w_mag_b;
                        r_neg_res <= w_op_signed & (busA[31] ^ busB[31]);
                        r_prod    <= w_op_mul ? {32'd0, w_mag_b} : {32'd0, w_mag_a};
                    end else if (start && op == OP_MTHI) begin
                        r_hi <= busA;
                    end else if (start && op == OP_MTLO) begin
                        r_lo <= busA;
                    end
                end
                S_RUN: begin
                    r_cnt  <= r_cnt + 6'd1;
                    r_prod <= w_step;
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
